// File: rtl/lock_equalizer_if.sv
// lock_equalizer_if: start/level request bus and valve/status response bus of the lock equalizer
interface lock_equalizer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] level_a;
  logic [WIDTH-1:0] level_b;
  logic             fill;
  logic             drain;
  logic             equal;
  logic             busy;
  logic             done;
  logic             fault;
  modport master (
    output start, level_a, level_b,
    input  fill, drain, equal, busy, done, fault
  );
  modport slave (
    input  start, level_a, level_b,
    output fill, drain, equal, busy, done, fault
  );
endinterface

// File: rtl/lock_equalizer.sv
// lock_equalizer: drives fill/drain valves until the chamber level matches the river level
module lock_equalizer #(
  parameter int WIDTH   = 8,
  parameter int TOL     = 0,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst_n,
  lock_equalizer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_SETTLE, S_DONE, S_FAULT} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ST_LAST = 8'(SETTLE - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  stab_q, stab_d;
  logic        fill_q, fill_d, drain_q, drain_d, fault_q, fault_d;
  logic [WIDTH:0] a_x, b_x, diff;
  logic        far, below, above;
  // one extra bit keeps the subtraction from wrapping for any level pair
  assign a_x   = {1'b0, bus.level_a};
  assign b_x   = {1'b0, bus.level_b};
  assign diff  = a_x >= b_x ? a_x - b_x : b_x - a_x;
  assign far   = 32'(diff) > 32'(TOL);
  assign below = far && a_x < b_x;
  assign above = far && a_x > b_x;
  assign bus.equal = !far;
  assign bus.fill  = fill_q;
  assign bus.drain = drain_q;
  assign bus.fault = fault_q;
  assign bus.busy  = state_q inside {S_FILL, S_DRAIN, S_SETTLE};
  assign bus.done  = state_q == S_DONE;
  // next state and counters; counters fall back to zero whenever their phase is left
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    stab_d  = '0;
    case (state_q)
      S_IDLE:   state_d = !bus.start ? S_IDLE : below ? S_FILL : above ? S_DRAIN : S_SETTLE;
      S_FILL: begin
        state_d = above ? S_DRAIN : !below ? S_SETTLE : cnt_q == TO_LAST ? S_FAULT : S_FILL;
        cnt_d   = state_d == S_FILL ? cnt_q + 16'd1 : '0;
      end
      S_DRAIN: begin
        state_d = below ? S_FILL : !above ? S_SETTLE : cnt_q == TO_LAST ? S_FAULT : S_DRAIN;
        cnt_d   = state_d == S_DRAIN ? cnt_q + 16'd1 : '0;
      end
      S_SETTLE: begin
        state_d = below ? S_FILL : above ? S_DRAIN : stab_q == ST_LAST ? S_DONE : S_SETTLE;
        stab_d  = state_d == S_SETTLE ? stab_q + 8'd1 : '0;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_FAULT;
    endcase
    fill_d  = state_q == S_FILL;
    drain_d = state_q == S_DRAIN;
    fault_d = fault_q | (state_q == S_FAULT);
  end
  // state and registered valve/fault outputs; reset drops the valves immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stab_q  <= '0;
      fill_q  <= 1'b0;
      drain_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_lock_equalizer.sv
// tb_lock_equalizer: directed and randomized checks of lock_equalizer against a phase-level model
module tb_lock_equalizer;
  localparam int W = 16, TOL = 2, SETTLE = 4, TIMEOUT = 8, MAXV = 65535;
  typedef enum {M_IDLE, M_FILL, M_DRAIN, M_SETTLE, M_DONE, M_FAULT} mode_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  mode_t mode = M_IDLE;
  int age = 0;
  bit m_fill = 0, m_drain = 0, m_fault = 0;
  int a = 0, b = 0;
  lock_equalizer_if #(.WIDTH(W)) bus ();
  lock_equalizer #(.WIDTH(W), .TOL(TOL), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int clamp(input int v);
    return v < 0 ? 0 : v > MAXV ? MAXV : v;
  endfunction
  task automatic model_reset();
    mode = M_IDLE; age = 0; m_fill = 0; m_drain = 0; m_fault = 0;
  endtask
  task automatic model_step(input bit st, input int la, input int lb);
    int d;
    bit lo, hi;
    mode_t nx;
    d = la - lb; lo = d < -TOL; hi = d > TOL;
    m_fill = mode == M_FILL; m_drain = mode == M_DRAIN; m_fault = m_fault | (mode == M_FAULT);
    age++;
    nx = mode;
    case (mode)
      M_IDLE:   if (st) nx = lo ? M_FILL : hi ? M_DRAIN : M_SETTLE;
      M_FILL:   nx = hi ? M_DRAIN : !lo ? M_SETTLE : age >= TIMEOUT ? M_FAULT : M_FILL;
      M_DRAIN:  nx = lo ? M_FILL : !hi ? M_SETTLE : age >= TIMEOUT ? M_FAULT : M_DRAIN;
      M_SETTLE: nx = lo ? M_FILL : hi ? M_DRAIN : age >= SETTLE ? M_DONE : M_SETTLE;
      M_DONE:   nx = M_IDLE;
      default:  nx = M_FAULT;
    endcase
    if (nx != mode) age = 0;
    mode = nx;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fill"}, bus.fill, 0);
    chk({tag, "_drain"}, bus.drain, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_fault"}, bus.fault, 0);
  endtask
  task automatic cycle(input bit st, input int la, input int lb, input bit rst);
    @(negedge clk);
    bus.start = st; bus.level_a = W'(la); bus.level_b = W'(lb);
    #1;
    chk("equal", bus.equal, int'(la - lb <= TOL && lb - la <= TOL));
    chk("fill", bus.fill, m_fill);
    chk("drain", bus.drain, m_drain);
    chk("busy", bus.busy, int'(mode inside {M_FILL, M_DRAIN, M_SETTLE}));
    chk("done", bus.done, int'(mode == M_DONE));
    chk("fault", bus.fault, m_fault);
    chk("valve_excl", bus.fill & bus.drain, 0);
    if (rst) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      #1 rst_n = 1'b1;
    end
    model_step(st, la, lb);
  endtask
  initial begin
    int r;
    bit st;
    bus.start = 1'b0; bus.level_a = '0; bus.level_b = '0;
    #2;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    cycle(1, 0, 10, 0);
    repeat (3) cycle(0, 0, 10, 0);
    repeat (7) cycle(0, 9, 10, 0);
    cycle(1, 200, 10, 0);
    repeat (2) cycle(0, 200, 10, 0);
    repeat (2) cycle(0, 12, 10, 0);
    repeat (2) cycle(0, 7, 10, 0);
    repeat (7) cycle(0, 10, 10, 0);
    cycle(1, 5, 5, 0);
    cycle(1, 5, 5, 0);
    repeat (6) cycle(0, 5, 5, 0);
    cycle(1, 0, MAXV, 0);
    repeat (12) cycle(0, 0, MAXV, 0);
    cycle(1, MAXV, 0, 0);
    chk("fault_sticky", bus.fault, 1);
    chk("fault_fill_off", bus.fill, 0);
    cycle(0, 0, 100, 1);
    cycle(1, 0, 100, 0);
    repeat (2) cycle(0, 0, 100, 0);
    repeat (3) cycle(0, 250, 100, 0);
    cycle(0, 0, 0, 1);
    cycle(1, MAXV, 0, 0);
    repeat (3) cycle(0, MAXV, 0, 0);
    cycle(0, MAXV, 0, 1);
    repeat (3) cycle(0, 0, MAXV, 0);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) ;
      else if (r < 60) a = clamp(b + $urandom_range(0, 8) - 4);
      else if (r < 72) a = clamp(a < b ? a + $urandom_range(0, 3000) : a - $urandom_range(0, 3000));
      else if (r < 82) b = $urandom_range(0, MAXV);
      else if (r < 88) begin a = $urandom_range(0, 1) * MAXV; b = $urandom_range(0, 1) * MAXV; end
      else a = $urandom_range(0, MAXV);
      st = $urandom_range(0, 3) == 0;
      cycle(st, a, b, $urandom_range(0, 99) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
